stack_core: RTL and testbench

STACK_CORE -- requirements
Module: stack_core

---
 rtl/stack_core_pkg.sv | 62 ++++++
 rtl/stack_core_lifo.sv | 60 ++++++
 rtl/stack_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_stack_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_core_pkg.sv
// Shared types for the stack machine: opcode encoding, ALU function select,
// controller states and per-opcode stack requirements.
package stack_core_pkg;

    // Opcode lives in bits [3:0] of the instruction word; upper bits are ignored.
    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpShl = 4'd2,
        OpShr = 4'd3,
        OpSra = 4'd4,
        OpAnd = 4'd5,
        OpOr  = 4'd6,
        OpXor = 4'd7,
        OpPsi = 4'd8,
        OpPsh = 4'd9,
        OpStr = 4'd10,
        OpDup = 4'd11,
        OpJpz = 4'd12,
        OpJpn = 4'd13,
        OpRet = 4'd14,
        OpNul = 4'd15
    } opcode_e;

    // ALU function equals the low three opcode bits of the ALU opcodes.
    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluShl = 3'd2,
        AluShr = 3'd3,
        AluSra = 3'd4,
        AluAnd = 3'd5,
        AluOr  = 3'd6,
        AluXor = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StImm,
        StLoad,
        StStore,
        StExec,
        StHalt,
        StFault
    } state_e;

    // Number of entries that must be on the stack before the opcode may run.
    function automatic logic [1:0] req_depth(input opcode_e op);
        case (op)
            OpAdd, OpSub, OpShl, OpShr, OpSra, OpAnd, OpOr, OpXor: return 2'd2;
            OpDup, OpStr, OpJpz, OpJpn, OpRet:                     return 2'd1;
            default:                                               return 2'd0;
        endcase
    endfunction

    // Opcodes that grow the stack by one entry.
    function automatic logic pushes(input opcode_e op);
        return (op == OpDup) || (op == OpPsi) || (op == OpPsh);
    endfunction

endpackage

// File: rtl/stack_core_lifo.sv
// Operand stack for stack_core.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset (clears count only)
//   push_i          push wdata_i
//   pop_i           drop the top entry
//   alu_i           pop two entries and push wdata_i (net one pop)
//   wdata_i         data for push / alu
//   top_o/second_o  top and second entries (undefined when not present)
//   count_o         number of valid entries, 0..STACK_DEPTH
module stack_core_lifo #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STACK_DEPTH = 16,
    localparam int unsigned IdxW       = $clog2(STACK_DEPTH),
    localparam int unsigned CntW       = IdxW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              alu_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] second_o,
    output logic [CntW-1:0]   count_o
);

    logic [DATA_W-1:0] mem_q [STACK_DEPTH];
    logic [CntW-1:0]   count_q;
    logic [IdxW-1:0]   top_idx;
    logic [IdxW-1:0]   sec_idx;
    logic [IdxW-1:0]   free_idx;

    assign top_idx  = IdxW'(count_q - CntW'(1));
    assign sec_idx  = IdxW'(count_q - CntW'(2));
    assign free_idx = count_q[IdxW-1:0];

    assign top_o    = mem_q[top_idx];
    assign second_o = mem_q[sec_idx];
    assign count_o  = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (push_i) begin
            count_q <= count_q + CntW'(1);
        end else if (alu_i || pop_i) begin
            count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset: entries above count are never observed.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[free_idx] <= wdata_i;
        end else if (alu_i) begin
            mem_q[sec_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/stack_core.sv
// Small stack-machine core: fetches one-word opcodes (optionally followed by an
// operand word) from a req/ack memory port, executes them on an operand stack,
// and stops on RET (halted) or on stack over/underflow (fault).
// Ports:
//   clock, reset            clock, synchronous active-low reset
//   mem_req/we/addr/wdata   memory request, held stable until mem_ack
//   mem_ack, mem_rdata      access complete, read data valid with mem_ack
//   halted, result          RET executed, top of stack at RET
//   fault                   stack overflow/underflow trapped
module stack_core
    import stack_core_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic              fault,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CntW = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned ShW  = $clog2(DATA_W);

    state_e            state_q, state_d;
    opcode_e           ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              st_push, st_pop, st_alu;
    logic [DATA_W-1:0] st_wdata, st_top, st_second;
    logic [CntW-1:0]   st_count;

    logic              taken, underflow, overflow;
    logic [DATA_W-1:0] alu_res;

    stack_core_lifo #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk_i    (clock),
        .rst_ni   (reset),
        .push_i   (st_push),
        .pop_i    (st_pop),
        .alu_i    (st_alu),
        .wdata_i  (st_wdata),
        .top_o    (st_top),
        .second_o (st_second),
        .count_o  (st_count)
    );

    function automatic logic [DATA_W-1:0] alu_calc(input alu_op_e f, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [ShW-1:0] sh;
        sh = b[ShW-1:0];
        unique case (f)
            AluAdd: return a + b;
            AluSub: return a - b;
            AluShl: return a << sh;
            AluShr: return a >> sh;
            AluSra: return $unsigned($signed(a) >>> sh);
            AluAnd: return a & b;
            AluOr:  return a | b;
            AluXor: return a ^ b;
        endcase
    endfunction

    assign alu_res   = alu_calc(alu_op_e'(ir_q[2:0]), st_second, st_top);
    assign taken     = ((ir_q == OpJpz) && (st_top == '0)) ||
                       ((ir_q == OpJpn) && st_top[DATA_W-1]);
    assign underflow = st_count < CntW'(req_depth(ir_q));
    assign overflow  = pushes(ir_q) && (st_count == CntW'(STACK_DEPTH));

    // Access states raise mem_req in their first cycle and finish on the cycle
    // mem_ack is seen; mem_req is registered so it drops the cycle after.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        opnd_d      = opnd_q;
        ld_d        = ld_q;
        result_d    = result_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        st_push     = 1'b0;
        st_pop      = 1'b0;
        st_alu      = 1'b0;
        st_wdata    = '0;

        unique case (state_q)
            StFetch: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ir_d      = opcode_e'(mem_rdata[3:0]);
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                if (underflow || overflow) begin
                    fault_d = 1'b1;
                    state_d = StFault;
                end else begin
                    unique case (ir_q)
                        OpAdd, OpSub, OpShl, OpShr, OpSra, OpAnd, OpOr, OpXor: begin
                            st_alu   = 1'b1;
                            st_wdata = alu_res;
                            pc_d     = pc_q + ADDR_W'(1);
                            state_d  = StFetch;
                        end
                        OpDup: begin
                            st_push  = 1'b1;
                            st_wdata = st_top;
                            pc_d     = pc_q + ADDR_W'(1);
                            state_d  = StFetch;
                        end
                        OpNul: begin
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                        OpPsi, OpPsh, OpStr: state_d = StImm;
                        OpJpz, OpJpn: begin
                            if (taken) begin
                                state_d = StImm;
                            end else begin
                                pc_d    = pc_q + ADDR_W'(2);
                                state_d = StFetch;
                            end
                        end
                        OpRet: begin
                            result_d = st_top;
                            halted_d = 1'b1;
                            state_d  = StHalt;
                        end
                    endcase
                end
            end
            StImm: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q + ADDR_W'(1);
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    opnd_d    = mem_rdata;
                    state_d   = (ir_q == OpPsh) ? StLoad :
                                (ir_q == OpStr) ? StStore : StExec;
                end
            end
            StLoad: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = opnd_q[ADDR_W-1:0];
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ld_d      = mem_rdata;
                    state_d   = StExec;
                end
            end
            StStore: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = opnd_q[ADDR_W-1:0];
                    mem_wdata_d = st_top;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                unique case (ir_q)
                    OpPsi: begin
                        st_push  = 1'b1;
                        st_wdata = opnd_q;
                        pc_d     = pc_q + ADDR_W'(2);
                    end
                    OpPsh: begin
                        st_push  = 1'b1;
                        st_wdata = ld_q;
                        pc_d     = pc_q + ADDR_W'(2);
                    end
                    OpStr: begin
                        st_pop = 1'b1;
                        pc_d   = pc_q + ADDR_W'(2);
                    end
                    // Only taken jumps reach EXEC.
                    default: pc_d = opnd_q[ADDR_W-1:0];
                endcase
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StFetch;
            ir_q        <= OpNul;
            pc_q        <= '0;
            opnd_q      <= '0;
            ld_q        <= '0;
            result_q    <= '0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            opnd_q      <= opnd_d;
            ld_q        <= ld_d;
            result_q    <= result_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign result    = result_q;

endmodule

// File: tb/tb_stack_core.sv
// Directed bench for stack_core (DATA_W=8, ADDR_W=8, STACK_DEPTH=4) with a
// req/ack memory model whose ack latency is programmable.
module tb_stack_core;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       halted, fault;
    logic [7:0] result;

    logic [7:0] mem [256];
    logic [8:0] trace [$];   // {we, addr} of every completed access
    int         ack_delay = 0;
    int         req_cycles = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } alu_vec_t;

    alu_vec_t alu_vecs [10] = '{
        '{8'h01, 8'h05, 8'h03, 8'h02},  // SUB 5-3
        '{8'h04, 8'h80, 8'h01, 8'hC0},  // SRA keeps sign
        '{8'h00, 8'hFF, 8'h01, 8'h00},  // ADD wraps
        '{8'h02, 8'h81, 8'h09, 8'h02},  // SHL uses b[2:0]=1
        '{8'h03, 8'h81, 8'h03, 8'h10},  // SHR
        '{8'h05, 8'hF0, 8'h3C, 8'h30},  // AND
        '{8'h06, 8'hF0, 8'h0F, 8'hFF},  // OR
        '{8'h07, 8'h0F, 8'h3C, 8'h33},  // XOR
        '{8'h01, 8'h03, 8'h05, 8'hFE},  // SUB wraps negative
        '{8'hF1, 8'h09, 8'h04, 8'h05}   // SUB, upper opcode bits ignored
    };

    logic [8:0] jump_tr [8] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h020, 9'h022, 9'h023, 9'h024};
    logic [8:0] ls_tr   [9] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h180, 9'h004, 9'h005, 9'h080,
                                9'h006};

    stack_core #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .STACK_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .halted    (halted),
        .fault     (fault),
        .result    (result)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after ack_delay wait cycles and checks that a
    // pending request keeps we/addr/wdata stable while it waits.
    initial begin
        int         cnt;
        bit         pending;
        logic [16:0] held;
        cnt = 0;
        pending = 0;
        held = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (pending) begin
                    check_eq("req_hold", {15'd0, 1'b0, 1'b0} | {mem_we, mem_addr, mem_wdata}, held);
                end else begin
                    pending = 1;
                    held = {mem_we, mem_addr, mem_wdata};
                    cnt = 0;
                end
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                    trace.push_back({mem_we, mem_addr});
                    pending = 0;
                end else begin
                    cnt++;
                end
            end else begin
                pending = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;  // NUL everywhere
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        trace.delete();
    endtask

    task automatic run(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (halted || fault) break;
        end
        check_eq({tag, "_done"}, {31'd0, halted | fault}, 1);
    endtask

    task automatic load_sub_prog();
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h05;
        mem[2] = 8'h08; mem[3] = 8'h03;
        mem[4] = 8'h01;
        mem[5] = 8'h0E;
    endtask

    initial begin
        // PSI 5, PSI 3, SUB, RET with zero-wait memory
        load_sub_prog();
        apply_reset();
        run("sub0", 200);
        check_eq("sub0_result", result, 8'h02);
        check_eq("sub0_halted", halted, 1);
        check_eq("sub0_fault", fault, 0);
        check_eq("sub0_trace_len", trace.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < trace.size()) check_eq("sub0_trace", trace[i], i);

        // Reset clears everything the previous program left behind
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_result", result, 0);

        // ALU table: PSI a, PSI b, op, RET
        foreach (alu_vecs[k]) begin
            clear_mem();
            mem[0] = 8'h08; mem[1] = alu_vecs[k].a;
            mem[2] = 8'h08; mem[3] = alu_vecs[k].b;
            mem[4] = alu_vecs[k].op;
            mem[5] = 8'h0E;
            apply_reset();
            run("alu", 200);
            check_eq($sformatf("alu%0d_result", k), result, alu_vecs[k].exp);
            check_eq($sformatf("alu%0d_fault", k), fault, 0);
        end

        // Same SUB program with three wait cycles on every access
        ack_delay = 3;
        load_sub_prog();
        apply_reset();
        run("sub3", 400);
        check_eq("sub3_result", result, 8'h02);
        check_eq("sub3_halted", halted, 1);
        check_eq("sub3_trace_len", trace.size(), 6);
        ack_delay = 0;

        // PSI 7, DUP, ADD, NUL, RET
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h07;
        mem[2] = 8'h0B; mem[3] = 8'h00; mem[4] = 8'h0F; mem[5] = 8'h0E;
        apply_reset();
        run("dup", 200);
        check_eq("dup_result", result, 8'h0E);

        // PSI 5A, STR 80, PSH 80, RET
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h5A;
        mem[2] = 8'h0A; mem[3] = 8'h80;
        mem[4] = 8'h09; mem[5] = 8'h80;
        mem[6] = 8'h0E;
        apply_reset();
        run("ls", 200);
        check_eq("ls_result", result, 8'h5A);
        check_eq("ls_mem80", mem[8'h80], 8'h5A);
        check_eq("ls_trace_len", trace.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < trace.size()) check_eq("ls_trace", trace[i], ls_tr[i]);

        // PSI 0, JPZ 20 (taken); @20: JPN 40 (not taken), PSI 77, RET
        clear_mem();
        mem[0] = 8'h08; mem[1] = 8'h00;
        mem[2] = 8'h0C; mem[3] = 8'h20;
        mem[8'h20] = 8'h0D; mem[8'h21] = 8'h40;
        mem[8'h22] = 8'h08; mem[8'h23] = 8'h77;
        mem[8'h24] = 8'h0E;
        apply_reset();
        run("jmp", 200);
        check_eq("jmp_result", result, 8'h77);
        check_eq("jmp_trace_len", trace.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < trace.size()) check_eq("jmp_trace", trace[i], jump_tr[i]);

        // Fill exactly four entries, then RET
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            mem[2 * i] = 8'h08;
            mem[2 * i + 1] = 8'(i + 1);
        end
        mem[8] = 8'h0E;
        apply_reset();
        run("fill", 200);
        check_eq("fill_halted", halted, 1);
        check_eq("fill_fault", fault, 0);
        check_eq("fill_result", result, 8'h04);

        // Four entries then DUP overflows; DUP sits at address 8
        mem[8] = 8'h0B;
        apply_reset();
        run("ovf", 200);
        check_eq("ovf_fault", fault, 1);
        check_eq("ovf_halted", halted, 0);
        check_eq("ovf_addr", mem_addr, 8'h08);
        check_eq("ovf_we", mem_we, 0);
        req_cycles = 0;
        repeat (10) @(negedge clock);
        #1;
        check_eq("ovf_no_req", req_cycles, 0);

        // ADD as first instruction underflows the cycle after DECODE
        clear_mem();
        mem[0] = 8'h00;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            if (mem_req && mem_ack) break;
        end
        check_eq("unf_fetch_ack", {31'd0, mem_req & mem_ack}, 1);
        @(posedge clock);
        #1;
        check_eq("unf_decode_fault", fault, 0);
        @(posedge clock);
        #1;
        check_eq("unf_fault", fault, 1);
        req_cycles = 0;
        repeat (10) @(negedge clock);
        #1;
        check_eq("unf_no_req", req_cycles, 0);

        // Reset while the fetch at address 2 is waiting for ack
        ack_delay = 5;
        load_sub_prog();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (mem_req && (mem_addr == 8'h02)) break;
        end
        check_eq("abort_pending", {31'd0, mem_req}, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("abort_req_low", mem_req, 0);
        @(negedge clock);
        reset = 1'b1;
        trace.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            if (mem_req) break;
        end
        check_eq("abort_refetch_req", mem_req, 1);
        check_eq("abort_refetch_addr", mem_addr, 8'h00);
        run("abort", 500);
        check_eq("abort_result", result, 8'h02);
        ack_delay = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
